// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: packs a little-endian byte stream (word-count header + payload) into
// 32-bit words for the instruction RAM and holds the core stalled until the image is in.
module imem_loader #(
  parameter int IMEM_POWER = 18,
  parameter int WORD       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [IMEM_POWER-1:0] waddr,
  output logic [WORD-1:0]       wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_LAST = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // One bit wider than the header count so 2^IMEM_POWER itself is representable.
  localparam logic [32:0] DEPTH = 33'd1 << IMEM_POWER;

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic [31:0]           count_q, count_d;
  logic [23:0]           shift_q, shift_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q, we_d;
  logic [IMEM_POWER-1:0] waddr_q, waddr_d;
  logic [WORD-1:0]       wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_hold_q, cpu_hold_d;

  logic                  accept;
  logic [31:0]           hdr_word;

  always_comb begin
    accept     = in_valid && in_ready_q;
    hdr_word   = {in_data, count_q[31:8]};
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    count_d    = count_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_idx_d = 2'd0;
          word_cnt_d = 32'd0;
        end
      end
      S_HDR: begin
        if (accept) begin
          count_d    = hdr_word;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (hdr_word == 32'd0)
              state_d = S_DONE;
            else if ({1'b0, hdr_word} > DEPTH)
              state_d = S_ERR;
            else
              state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {in_data, shift_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            waddr_d    = word_cnt_q[IMEM_POWER-1:0];
            wdata_d    = {in_data, shift_q};
            word_cnt_d = word_cnt_q + 32'd1;
            if (word_cnt_q == count_q - 32'd1)
              state_d = S_LAST;
          end
        end
      end
      // The final write is on the bus this cycle; release the core only after it.
      S_LAST:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
    busy_d     = in_ready_d || (state_d == S_LAST);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      word_cnt_q <= 32'd0;
      count_q    <= 32'd0;
      shift_q    <= 24'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = cpu_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: two loaders (16-word and 4-word memories) share one byte stream;
// a stream-level model is checked every cycle, plus literal checks per scenario.
module tb_imem_loader;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_FIN  = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR  = 4;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;

  logic        ir0, we0, busy0, done0, err0, hold0;
  logic [3:0]  waddr0;
  logic [31:0] wdata0;
  logic        ir1, we1, busy1, done1, err1, hold1;
  logic [1:0]  waddr1;
  logic [31:0] wdata1;

  imem_loader #(.IMEM_POWER(4), .WORD(32)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir0), .we(we0), .waddr(waddr0), .wdata(wdata0), .busy(busy0),
    .done(done0), .error(err0), .cpu_hold(hold0)
  );

  imem_loader #(.IMEM_POWER(2), .WORD(32)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .we(we1), .waddr(waddr1), .wdata(wdata1), .busy(busy1),
    .done(done1), .error(err1), .cpu_hold(hold1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Stream-level model, one slot per DUT.
  int          mode [2];
  int          nb   [2];
  longint      hn   [2];
  logic [31:0] acc  [2];
  logic        e_we [2];
  logic [31:0] e_wa [2];
  logic [31:0] e_wd [2];
  logic        e_wchk [2];

  logic [31:0] la0[$], ld0[$], la1[$], ld1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    mode[d] = M_IDLE; nb[d] = 0; hn[d] = 0; acc[d] = 32'd0;
    e_we[d] = 1'b0; e_wa[d] = 32'd0; e_wd[d] = 32'd0; e_wchk[d] = 1'b1;
  endtask

  task automatic model_step(input int d, input int p);
    int widx;
    e_we[d] = 1'b0;
    e_wchk[d] = 1'b0;
    case (mode[d])
      M_IDLE, M_DONE, M_ERR: if (start) begin mode[d] = M_LOAD; nb[d] = 0; hn[d] = 0; end
      M_LOAD: if (in_valid) begin
        if (nb[d] < 4) hn[d] = hn[d] | (longint'(in_data) << (8 * nb[d]));
        else acc[d][(nb[d] % 4) * 8 +: 8] = in_data;
        nb[d]++;
        if (nb[d] == 4) begin
          if (hn[d] == 0) mode[d] = M_DONE;
          else if (hn[d] > (longint'(1) << p)) mode[d] = M_ERR;
        end else if (nb[d] > 4 && nb[d] % 4 == 0) begin
          widx = (nb[d] - 4) / 4 - 1;
          e_we[d] = 1'b1; e_wchk[d] = 1'b1;
          e_wa[d] = 32'(widx); e_wd[d] = acc[d];
          if (longint'(widx) == hn[d] - 1) mode[d] = M_FIN;
        end
      end
      M_FIN: mode[d] = M_DONE;
      default: mode[d] = M_IDLE;
    endcase
  endtask

  task automatic check_dut(input int d, input logic ir, input logic we, input logic [31:0] wa,
                           input logic [31:0] wd, input logic bsy, input logic dn,
                           input logic er, input logic hd);
    int m;
    m = mode[d];
    chk($sformatf("d%0d_in_ready", d), 32'(ir), 32'(m == M_LOAD));
    chk($sformatf("d%0d_we", d), 32'(we), 32'(e_we[d]));
    chk($sformatf("d%0d_busy", d), 32'(bsy), 32'(m == M_LOAD || m == M_FIN));
    chk($sformatf("d%0d_done", d), 32'(dn), 32'(m == M_DONE));
    chk($sformatf("d%0d_error", d), 32'(er), 32'(m == M_ERR));
    chk($sformatf("d%0d_cpu_hold", d), 32'(hd), 32'(m != M_DONE));
    if (e_wchk[d]) begin
      chk($sformatf("d%0d_waddr", d), wa, e_wa[d]);
      chk($sformatf("d%0d_wdata", d), wd, e_wd[d]);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      model_reset(0);
      model_reset(1);
    end
    check_dut(0, ir0, we0, 32'(waddr0), wdata0, busy0, done0, err0, hold0);
    check_dut(1, ir1, we1, 32'(waddr1), wdata1, busy1, done1, err1, hold1);
    if (we0 === 1'b1) begin la0.push_back(32'(waddr0)); ld0.push_back(wdata0); end
    if (we1 === 1'b1) begin la1.push_back(32'(waddr1)); ld1.push_back(wdata1); end
    if (reset) begin
      model_step(0, 4);
      model_step(1, 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    la0.delete(); ld0.delete(); la1.delete(); ld1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic taken, rdy;
    taken = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 20 && !taken; k++) begin
      rdy = ir0;
      tick();
      if (rdy) taken = 1'b1;
    end
    in_valid = 1'b0;
    if (!taken) chk("send_byte_timeout", 32'(taken), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    in_data  = 8'hAA;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    chk("rst_cpu_hold", 32'(hold0), 32'd1);
    chk("rst_in_ready", 32'(ir0), 32'd0);
    reset = 1'b1;
    tick();

    // Two-word image, one byte per cycle.
    clear_logs();
    pulse_start();
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    chk("t1_we_final", 32'(we0), 32'd1);
    chk("t1_hold_during_last", 32'(hold0), 32'd1);
    chk("t1_in_ready_last", 32'(ir0), 32'd0);
    tick();
    chk("t1_hold_released", 32'(hold0), 32'd0);
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_nwrites", 32'(la0.size()), 32'd2);
    chk("t1_addr0", la0[0], 32'd0);
    chk("t1_data0", ld0[0], 32'h0000_0013);
    chk("t1_addr1", la0[1], 32'd1);
    chk("t1_data1", ld0[1], 32'h0010_0093);

    // Empty image.
    clear_logs();
    pulse_start();
    send_word(32'd0);
    chk("t2_done", 32'(done0), 32'd1);
    chk("t2_hold", 32'(hold0), 32'd0);
    tick();
    chk("t2_nwrites", 32'(la0.size()), 32'd0);

    // Oversized header (17 > 16 and > 4), bytes ignored in ERR, restart.
    pulse_start();
    send_word(32'd17);
    chk("t3_error", 32'(err0), 32'd1);
    chk("t3_error_small", 32'(err1), 32'd1);
    chk("t3_in_ready", 32'(ir0), 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t3_error_held", 32'(err0), 32'd1);
    chk("t3_nwrites", 32'(la0.size()), 32'd0);
    pulse_start();
    chk("t3_error_cleared", 32'(err0), 32'd0);
    chk("t3_hdr_ready", 32'(ir0), 32'd1);

    // Single word with gaps: valid pattern 1,0,0,1,0,1,1 over the payload.
    clear_logs();
    send_word(32'd1);
    send_byte(8'hEF);
    gap(2);
    send_byte(8'hBE);
    gap(1);
    send_byte(8'hAD);
    send_byte(8'hDE);
    tick();
    chk("t4_done", 32'(done0), 32'd1);
    chk("t4_nwrites", 32'(la0.size()), 32'd1);
    chk("t4_addr", la0[0], 32'd0);
    chk("t4_data", ld0[0], 32'hDEAD_BEEF);

    // start ignored mid-DATA, then reset mid-word.
    clear_logs();
    pulse_start();
    send_word(32'd3);
    send_word(32'hCAFE_F00D);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    chk("t5_busy_after_start", 32'(busy0), 32'd1);
    chk("t5_ready_after_start", 32'(ir0), 32'd1);
    send_byte(8'h33);
    reset = 1'b0;
    #1;
    chk("t5_rst_we", 32'(we0), 32'd0);
    chk("t5_rst_busy", 32'(busy0), 32'd0);
    chk("t5_rst_hold", 32'(hold0), 32'd1);
    chk("t5_rst_waddr", 32'(waddr0), 32'd0);
    chk("t5_rst_wdata", wdata0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t5_idle_ready", 32'(ir0), 32'd0);
    chk("t5_idle_hold", 32'(hold0), 32'd1);
    chk("t5_nwrites", 32'(la0.size()), 32'd1);
    chk("t5_data", ld0[0], 32'hCAFE_F00D);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (2) tick();
    in_valid = 1'b0;

    // Fill the 4-word memory exactly; last word at address 3.
    clear_logs();
    pulse_start();
    send_word(32'd4);
    for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + 32'(i));
    tick();
    chk("t6_done_small", 32'(done1), 32'd1);
    chk("t6_error_small", 32'(err1), 32'd0);
    chk("t6_nwrites_small", 32'(la1.size()), 32'd4);
    chk("t6_last_addr", la1[3], 32'd3);
    chk("t6_last_data", ld1[3], 32'hA000_0003);
    chk("t6_first_addr", la1[0], 32'd0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
